// File: rtl/mips_cpu_muldiv_seq.sv
// Sequential HI/LO multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Define MULDIV_ACCUM_EN to enable MADD/MADDU/MSUB/MSUBU accumulation into {hi,lo}.
module mips_cpu_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_MULT  = 4'b0000;
    localparam logic [3:0] OP_MULTU = 4'b0001;
    localparam logic [3:0] OP_DIV   = 4'b0010;
    localparam logic [3:0] OP_DIVU  = 4'b0011;
    localparam logic [3:0] OP_MTHI  = 4'b0100;
    localparam logic [3:0] OP_MTLO  = 4'b0101;
`ifdef MULDIV_ACCUM_EN
    localparam logic [3:0] OP_MADD  = 4'b0110;
    localparam logic [3:0] OP_MADDU = 4'b0111;
    localparam logic [3:0] OP_MSUB  = 4'b1000;
    localparam logic [3:0] OP_MSUBU = 4'b1001;
`endif

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] p;       // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   m;       // multiplicand or divisor magnitude
    logic               is_div;
    logic               neg_lo;
    logic               neg_hi;
`ifdef MULDIV_ACCUM_EN
    logic               acc;
    logic               acc_sub;
`endif

    // Decode of the incoming op
    logic dec_mul, dec_div, dec_sgn;
`ifdef MULDIV_ACCUM_EN
    logic dec_acc, dec_sub;
`endif

    always_comb begin
        dec_mul = 1'b0;
        dec_div = 1'b0;
        dec_sgn = 1'b0;
`ifdef MULDIV_ACCUM_EN
        dec_acc = 1'b0;
        dec_sub = 1'b0;
`endif
        case (op)
            OP_MULT:  begin dec_mul = 1'b1; dec_sgn = 1'b1; end
            OP_MULTU: dec_mul = 1'b1;
            OP_DIV:   begin dec_div = 1'b1; dec_sgn = 1'b1; end
            OP_DIVU:  dec_div = 1'b1;
`ifdef MULDIV_ACCUM_EN
            OP_MADD:  begin dec_mul = 1'b1; dec_sgn = 1'b1; dec_acc = 1'b1; end
            OP_MADDU: begin dec_mul = 1'b1; dec_acc = 1'b1; end
            OP_MSUB:  begin dec_mul = 1'b1; dec_sgn = 1'b1; dec_acc = 1'b1; dec_sub = 1'b1; end
            OP_MSUBU: begin dec_mul = 1'b1; dec_acc = 1'b1; dec_sub = 1'b1; end
`endif
            default: ;
        endcase
    end

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign a_neg = dec_sgn & a[WIDTH-1];
    assign b_neg = dec_sgn & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // One iteration of either algorithm
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] step_next;

    assign mul_sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, (p[0] ? m : {WIDTH{1'b0}})};
    assign div_shift = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, m};
    // The true difference is below 2^WIDTH whenever it is used, so WIDTH bits suffice
    assign div_diff  = div_shift[WIDTH-1:0] - m;
    assign step_next = is_div ? {(div_ge ? div_diff : div_shift[WIDTH-1:0]), p[WIDTH-2:0], div_ge}
                              : {mul_sum, p[WIDTH-1:1]};

    // Sign correction applied in FIX
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem;

    assign prod = neg_lo ? -p : p;
    assign quot = neg_lo ? -p[WIDTH-1:0] : p[WIDTH-1:0];
    assign rem  = neg_hi ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];

`ifdef MULDIV_ACCUM_EN
    logic [2*WIDTH-1:0] acc_sum;
    assign acc_sum = acc_sub ? ({hi, lo} - prod) : ({hi, lo} + prod);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            count       <= '0;
            p           <= '0;
            m           <= '0;
            is_div      <= 1'b0;
            neg_lo      <= 1'b0;
            neg_hi      <= 1'b0;
`ifdef MULDIV_ACCUM_EN
            acc         <= 1'b0;
            acc_sub     <= 1'b0;
`endif
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        if (dec_mul || (dec_div && b != '0)) begin
                            state   <= RUN;
                            busy    <= 1'b1;
                            count   <= CW'(WIDTH - 1);
                            p       <= {{WIDTH{1'b0}}, (dec_div ? a_mag : b_mag)};
                            m       <= dec_div ? b_mag : a_mag;
                            is_div  <= dec_div;
                            neg_lo  <= a_neg ^ b_neg;
                            neg_hi  <= a_neg;
`ifdef MULDIV_ACCUM_EN
                            acc     <= dec_acc;
                            acc_sub <= dec_sub;
`endif
                        end else begin
                            // Moves, divide-by-zero and no-ops finish in one cycle
                            done        <= 1'b1;
                            div_by_zero <= dec_div;
                            if (op == OP_MTHI) hi <= a;
                            if (op == OP_MTLO) lo <= a;
                        end
                    end
                end
                RUN: begin
                    p     <= step_next;
                    count <= count - 1'b1;
                    if (count == '0) state <= FIX;
                end
                FIX: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    if (is_div) begin
                        lo <= quot;
                        hi <= rem;
                    end else begin
`ifdef MULDIV_ACCUM_EN
                        {hi, lo} <= acc ? acc_sum : prod;
`else
                        {hi, lo} <= prod;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_muldiv_seq.sv
// Self-checking bench for mips_cpu_muldiv_seq: directed cases plus randomized ops against an arithmetic model.
module tb_mips_cpu_muldiv_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int n_checks = 0;
    int n_fail = 0;
    logic [W-1:0] mhi = '0;
    logic [W-1:0] mlo = '0;

    mips_cpu_muldiv_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Architectural model: updates mhi/mlo and returns expected done cycle and flag
    function automatic void ref_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   output int lat, output logic dz);
        longint sx, sy;
        logic [2*W-1:0] pr, acc;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        acc = {mhi, mlo};
        lat = 1;
        dz  = 1'b0;
        case (o)
            4'd0: begin pr = sx * sy; {mhi, mlo} = pr; lat = W + 2; end
            4'd1: begin pr = {32'd0, x} * {32'd0, y}; {mhi, mlo} = pr; lat = W + 2; end
            4'd2: if (y == 0) dz = 1'b1;
                  else begin mlo = 32'(sx / sy); mhi = 32'(sx % sy); lat = W + 2; end
            4'd3: if (y == 0) dz = 1'b1;
                  else begin mlo = x / y; mhi = x % y; lat = W + 2; end
            4'd4: mhi = x;
            4'd5: mlo = x;
`ifdef MULDIV_ACCUM_EN
            4'd6: begin pr = sx * sy; {mhi, mlo} = acc + pr; lat = W + 2; end
            4'd7: begin pr = {32'd0, x} * {32'd0, y}; {mhi, mlo} = acc + pr; lat = W + 2; end
            4'd8: begin pr = sx * sy; {mhi, mlo} = acc - pr; lat = W + 2; end
            4'd9: begin pr = {32'd0, x} * {32'd0, y}; {mhi, mlo} = acc - pr; lat = W + 2; end
`endif
            default: ;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge of the done cycle
    task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output int lat, output int bcnt, output logic dz);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; op = 4'($urandom_range(0, 15));
        lat = 0; bcnt = 0; dz = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            if (busy) bcnt++;
            if (done) begin lat = n; dz = div_by_zero; break; end
            @(negedge clk);
        end
        if (lat == 0) begin
            n_checks++; n_fail++;
            $display("FAIL issue_timeout: op=%0d got no done within 200 cycles", o);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
        n_checks++; if ({hi, lo} !== 64'd0) begin n_fail++; $display("FAIL reset_hilo: got %h want 0", {hi, lo}); end
        reset = 1'b1; mhi = '0; mlo = '0;
        @(negedge clk);
    endtask

    task automatic test_mult();
        int lat, el, bc; logic dz, edz;
        ref_op(4'd0, 32'hFFFFFFFD, 32'd7, el, edz);
        issue(4'd0, 32'hFFFFFFFD, 32'd7, lat, bc, dz);
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL mult_latency: got %0d want 34", lat); end
        n_checks++; if (bc !== 33) begin n_fail++; $display("FAIL mult_busy_cycles: got %0d want 33", bc); end
        n_checks++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        n_checks++; if (lo !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mult_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_div();
        logic [3:0]   ops[3] = '{4'd3, 4'd2, 4'd2};
        logic [W-1:0] xs[3]  = '{32'd100, 32'hFFFFFFF9, 32'h80000000};
        logic [W-1:0] ys[3]  = '{32'd7, 32'd2, 32'hFFFFFFFF};
        logic [W-1:0] qs[3]  = '{32'd14, 32'hFFFFFFFD, 32'h80000000};
        logic [W-1:0] rs[3]  = '{32'd2, 32'hFFFFFFFF, 32'd0};
        int lat, el, bc; logic dz, edz;
        for (int i = 0; i < 3; i++) begin
            ref_op(ops[i], xs[i], ys[i], el, edz);
            issue(ops[i], xs[i], ys[i], lat, bc, dz);
            n_checks++; if (lo !== qs[i]) begin n_fail++; $display("FAIL div%0d_lo: got %h want %h", i, lo, qs[i]); end
            n_checks++; if (hi !== rs[i]) begin n_fail++; $display("FAIL div%0d_hi: got %h want %h", i, hi, rs[i]); end
            n_checks++; if (lat !== 34 || dz !== 1'b0) begin n_fail++; $display("FAIL div%0d_done: got lat=%0d dz=%b want 34/0", i, lat, dz); end
        end
    endtask

    task automatic test_div_zero();
        int lat, el, bc; logic dz, edz;
        ref_op(4'd4, 32'h55, 32'd0, el, edz);
        issue(4'd4, 32'h55, 32'd0, lat, bc, dz);
        n_checks++; if (lat !== 1 || bc !== 0 || hi !== 32'h55) begin n_fail++; $display("FAIL mthi: got lat=%0d busy=%0d hi=%h want 1/0/55", lat, bc, hi); end
        ref_op(4'd5, 32'h55, 32'd0, el, edz);
        issue(4'd5, 32'h55, 32'd0, lat, bc, dz);
        n_checks++; if (lat !== 1 || lo !== 32'h55) begin n_fail++; $display("FAIL mtlo: got lat=%0d lo=%h want 1/55", lat, lo); end
        ref_op(4'd2, 32'h1234, 32'd0, el, edz);
        issue(4'd2, 32'h1234, 32'd0, lat, bc, dz);
        n_checks++; if (lat !== 1 || dz !== 1'b1 || bc !== 0) begin n_fail++; $display("FAIL divzero_flag: got lat=%0d dz=%b busy=%0d want 1/1/0", lat, dz, bc); end
        n_checks++; if (hi !== 32'h55 || lo !== 32'h55) begin n_fail++; $display("FAIL divzero_hilo: got %h/%h want 55/55", hi, lo); end
        @(negedge clk);
        n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL divzero_pulse: got %b want 0", div_by_zero); end
    endtask

    task automatic test_busy_ignore();
        int lat, el; logic edz, saw;
        ref_op(4'd1, 32'h1000, 32'd3, el, edz);
        op = 4'd1; a = 32'h1000; b = 32'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; lat = 0; saw = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            if (n == 5) begin start = 1'b1; op = 4'd4; a = 32'h1234; end
            if (n == 6) start = 1'b0;
            if (hi === 32'h1234) saw = 1'b1;
            if (done) begin lat = n; break; end
            @(negedge clk);
        end
        repeat (2) begin @(negedge clk); if (hi === 32'h1234) saw = 1'b1; end
        n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL busy_ignore_mthi: got hi=1234 seen want never"); end
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL busy_ignore_latency: got %0d want 34", lat); end
        n_checks++; if (hi !== mhi || lo !== mlo) begin n_fail++; $display("FAIL busy_ignore_result: got %h/%h want %h/%h", hi, lo, mhi, mlo); end
    endtask

    task automatic test_reset_mid();
        int lat, el, bc; logic dz, edz, saw;
        ref_op(4'd4, 32'hAAAA, 32'd0, el, edz); issue(4'd4, 32'hAAAA, 32'd0, lat, bc, dz);
        ref_op(4'd5, 32'hBBBB, 32'd0, el, edz); issue(4'd5, 32'hBBBB, 32'd0, lat, bc, dz);
        op = 4'd3; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            if (n == 10) reset = 1'b0;
            else @(negedge clk);
        end
        @(negedge clk);
        reset = 1'b1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midreset_ctrl: got busy=%b done=%b want 0/0", busy, done); end
        n_checks++; if (hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL midreset_hilo: got %h/%h want 0/0", hi, lo); end
        saw = 1'b0;
        repeat (40) begin @(negedge clk); if (done || busy) saw = 1'b1; end
        n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL midreset_discard: got activity after reset want none"); end
        mhi = '0; mlo = '0;
    endtask

    task automatic test_accum();
        int lat, el, bc; logic dz, edz;
        ref_op(4'd5, 32'd5, 32'd0, el, edz); issue(4'd5, 32'd5, 32'd0, lat, bc, dz);
        ref_op(4'd4, 32'd0, 32'd0, el, edz); issue(4'd4, 32'd0, 32'd0, lat, bc, dz);
        ref_op(4'd7, 32'd3, 32'd4, el, edz);
        issue(4'd7, 32'd3, 32'd4, lat, bc, dz);
`ifdef MULDIV_ACCUM_EN
        n_checks++; if (lat !== 34 || lo !== 32'd17 || hi !== 32'd0) begin n_fail++; $display("FAIL maddu: got lat=%0d lo=%0d hi=%0d want 34/17/0", lat, lo, hi); end
`else
        n_checks++; if (lat !== 1 || lo !== 32'd5 || hi !== 32'd0) begin n_fail++; $display("FAIL maddu_noop: got lat=%0d lo=%0d hi=%0d want 1/5/0", lat, lo, hi); end
`endif
    endtask

    // Ops are issued in the done cycle of the previous op unless a gap is drawn
    task automatic test_random();
        int lat, el, bc; logic dz, edz;
        logic [3:0] o; logic [W-1:0] x, y;
        for (int i = 0; i < 80; i++) begin
            o = 4'($urandom_range(0, 15));
            x = $urandom; y = $urandom;
            case ($urandom_range(0, 7))
                0: y = '0;
                1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
                2: y = 32'($urandom_range(1, 20));
                3: x = 32'($urandom_range(0, 50));
                default: ;
            endcase
            ref_op(o, x, y, el, edz);
            issue(o, x, y, lat, bc, dz);
            n_checks++; if (lat !== el) begin n_fail++; $display("FAIL rand%0d_latency: op=%0d got %0d want %0d", i, o, lat, el); end
            n_checks++; if (bc !== ((el > 1) ? W + 1 : 0)) begin n_fail++; $display("FAIL rand%0d_busy: op=%0d got %0d want %0d", i, o, bc, (el > 1) ? W + 1 : 0); end
            n_checks++; if (dz !== edz) begin n_fail++; $display("FAIL rand%0d_dbz: op=%0d got %b want %b", i, o, dz, edz); end
            n_checks++; if (hi !== mhi || lo !== mlo) begin n_fail++; $display("FAIL rand%0d_hilo: op=%0d a=%h b=%h got %h/%h want %h/%h", i, o, x, y, hi, lo, mhi, mlo); end
            repeat ($urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_busy_ignore();
        test_reset_mid();
        test_accum();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
